// File: rtl/cache_data_bank.sv
// Set-associative cache data array: WAYS independent line stores sharing one
// request port, with byte-enabled word writes, full-line fills, one-cycle
// registered reads and a self-sequencing clear engine that zeroes every set.
module cache_data_bank #(
  parameter  int WAYS   = 4,
  parameter  int SETS   = 256,
  parameter  int LINE_W = 128,
  parameter  int WORD_W = 32,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int OFS_W  = ((LINE_W / WORD_W) > 1) ? $clog2(LINE_W / WORD_W) : 1,
  localparam int BE_W   = WORD_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic              req_fill_i,
  input  logic [IDX_W-1:0]  req_index_i,
  input  logic [WAY_W-1:0]  req_way_i,
  input  logic [OFS_W-1:0]  req_word_i,
  input  logic [BE_W-1:0]   req_be_i,
  input  logic [LINE_W-1:0] req_wdata_i,
  output logic [LINE_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              clear_i,
  output logic              busy_o
);

  localparam int NWORDS = LINE_W / WORD_W;
  localparam int NBYTES = LINE_W / 8;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic               rvalid_q;
  logic               rd_ok_q;   // at least one read since reset; gates rdata_o to zero
  logic [WAY_W-1:0]   rd_way_q;  // way whose read register drives rdata_o

  logic               clearing;
  logic               accept;
  logic               rd_acc;
  logic               wr_acc;
  logic [IDX_W-1:0]   wr_idx;
  logic [LINE_W-1:0]  wr_line;
  logic [NBYTES-1:0]  wr_be;
  logic [LINE_W-1:0]  way_rdata [WAYS];

  // State register: reset always restarts the clear from set 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic: sweep all sets once, or restart the sweep on clear_i
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Output logic: ready depends only on state and clear_i, never on valid
  always_comb begin
    clearing    = (state_q == ST_CLEAR);
    busy_o      = clearing;
    req_ready_o = (state_q == ST_IDLE) && !clear_i;
  end

  assign accept = req_valid_i && req_ready_o;
  assign rd_acc = accept && !req_we_i;
  assign wr_acc = accept && req_we_i;

  // Shared write data/enables: the clear writes zero lines, a fill writes the
  // whole line, a word write replicates the word and masks it into position
  always_comb begin
    wr_idx = clearing ? clr_idx_q : req_index_i;
    if (clearing) begin
      wr_line = '0;
      wr_be   = '1;
    end else if (req_fill_i) begin
      wr_line = req_wdata_i;
      wr_be   = '1;
    end else begin
      wr_line = {NWORDS{req_wdata_i[WORD_W-1:0]}};
      wr_be   = NBYTES'(req_be_i) << (req_word_i * BE_W);
    end
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [LINE_W-1:0] mem_q [SETS];
    logic [LINE_W-1:0] rd_q;
    logic              we_w;
    logic              re_w;

    assign we_w = clearing || (wr_acc && (req_way_i == WAY_W'(gi)));
    assign re_w = rd_acc && (req_way_i == WAY_W'(gi));

    // Per-way RAM: byte-enabled write port and registered read port
    always_ff @(posedge clk_i) begin
      if (we_w) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_line[8*b +: 8];
        end
      end
      if (re_w) rd_q <= mem_q[req_index_i];
    end

    assign way_rdata[gi] = rd_q;
  end

  // Read pipeline tracking: rvalid pulse and which way's register to present
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rd_ok_q  <= 1'b0;
      rd_way_q <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rd_ok_q  <= 1'b1;
        rd_way_q <= req_way_i;
      end
    end
  end

  // Output mux: the selected way's read register only changes on its own read,
  // so rdata_o holds until the next accepted read
  always_comb begin
    rdata_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_ok_q && (rd_way_q == WAY_W'(w))) rdata_o = way_rdata[w];
    end
  end

  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_cache_data_bank.sv
// Self-checking bench for cache_data_bank: hand-computed vector table,
// hand-written clear/reset sequences, then random traffic against a
// behavioural line-array model.
module tb_cache_data_bank;

  localparam int WAYS   = 4;
  localparam int SETS   = 256;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_we_i;
  logic         req_fill_i;
  logic [7:0]   req_index_i;
  logic [1:0]   req_way_i;
  logic [1:0]   req_word_i;
  logic [3:0]   req_be_i;
  logic [127:0] req_wdata_i;
  logic [127:0] rdata_o;
  logic         rvalid_o;
  logic         clear_i;
  logic         busy_o;

  cache_data_bank #(
    .WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .WORD_W(WORD_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_fill_i(req_fill_i),
    .req_index_i(req_index_i), .req_way_i(req_way_i),
    .req_word_i(req_word_i), .req_be_i(req_be_i),
    .req_wdata_i(req_wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .clear_i(clear_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: line contents, remaining clear cycles, last read value
  logic [127:0] model_mem [SETS][WAYS];
  int           clear_left;
  logic [127:0] model_rdata;
  int           n_tests = 0;
  int           n_fail  = 0;

  typedef struct {
    bit           we;
    bit           fill;
    int           idx;
    int           way;
    int           word;
    logic [3:0]   be;
    logic [127:0] wd;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs
  task automatic step(input bit v, input bit we, input bit fill, input int idx, input int way,
                      input int word, input logic [3:0] be, input logic [127:0] wd,
                      input bit clr, output bit acc);
    bit exp_ready;
    bit exp_rvalid;
    req_valid_i = v;
    req_we_i    = we;
    req_fill_i  = fill;
    req_index_i = idx[7:0];
    req_way_i   = way[1:0];
    req_word_i  = word[1:0];
    req_be_i    = be;
    req_wdata_i = wd;
    clear_i     = clr;
    #1;
    exp_ready = (clear_left == 0) && !clr;
    check("ready", {127'b0, req_ready_o}, {127'b0, exp_ready});
    acc = v && exp_ready;
    @(posedge clk_i);
    #1;
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) begin
        foreach (model_mem[s, w]) model_mem[s][w] = '0;
      end
    end else if (clr) begin
      clear_left = SETS;
    end
    exp_rvalid = acc && !we;
    if (acc && !we) begin
      model_rdata = model_mem[idx][way];
    end else if (acc && fill) begin
      model_mem[idx][way] = wd;
    end else if (acc) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[idx][way][word*32 + b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    check("busy", {127'b0, busy_o}, {127'b0, (clear_left > 0)});
    check("rvalid", {127'b0, rvalid_o}, {127'b0, exp_rvalid});
    check("rdata", rdata_o, model_rdata);
    if (v || clr)
      $display("[TB] t=%0t v=%0d we=%0d fill=%0d idx=%0d way=%0d word=%0d be=%h clr=%0d acc=%0d rvalid=%0b rdata=%h",
               $time, v, we, fill, idx, way, word, be, clr, acc, rvalid_o, rdata_o);
  endtask

  task automatic idle_step();
    bit acc;
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 4'h0, '0, 1'b0, acc);
  endtask

  // Run idle cycles until ready rises (bounded); return the cycle count
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < 400) begin
      idle_step();
      cnt++;
      if (req_ready_o) break;
    end
  endtask

  initial begin
    bit acc;
    int cnt;
    int busy_cycles;

    vecs[0]  = '{1, 1, 5, 2, 0, 4'h0, 128'h0123456789ABCDEF0123456789ABCDEF, '0};
    vecs[1]  = '{0, 0, 5, 2, 0, 4'h0, '0, 128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[2]  = '{0, 0, 5, 1, 0, 4'h0, '0, 128'h0};
    vecs[3]  = '{1, 1, 7, 0, 0, 4'h0, {128{1'b1}}, '0};
    vecs[4]  = '{1, 0, 7, 0, 1, 4'b0101, 128'hAABBCCDD, '0};
    vecs[5]  = '{0, 0, 7, 0, 0, 4'h0, '0, 128'hFFFFFFFF_FFFFFFFF_FFBBFFDD_FFFFFFFF};
    vecs[6]  = '{1, 0, 7, 0, 2, 4'b0000, 128'h12345678, '0};
    vecs[7]  = '{0, 0, 7, 0, 0, 4'h0, '0, 128'hFFFFFFFF_FFFFFFFF_FFBBFFDD_FFFFFFFF};
    vecs[8]  = '{0, 0, 5, 2, 0, 4'h0, '0, 128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[9]  = '{1, 1, 9, 3, 0, 4'h0, 128'hDEADBEEF_00000001_CAFEF00D_80000000, '0};
    vecs[10] = '{0, 0, 9, 3, 0, 4'h0, '0, 128'hDEADBEEF_00000001_CAFEF00D_80000000};

    foreach (model_mem[s, w]) model_mem[s][w] = 'x;
    model_rdata = '0;
    clear_left  = SETS;
    rst_ni = 1'b0;
    req_valid_i = 0; req_we_i = 0; req_fill_i = 0; req_index_i = '0; req_way_i = '0;
    req_word_i = '0; req_be_i = '0; req_wdata_i = '0; clear_i = 0;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rvalid", {127'b0, rvalid_o}, 128'h0);
    check("rst_rdata", rdata_o, 128'h0);
    check("rst_busy", {127'b0, busy_o}, 128'h1);
    check("rst_ready", {127'b0, req_ready_o}, 128'h0);
    rst_ni = 1'b1;

    // Initial clear lasts exactly SETS cycles
    wait_ready(cnt);
    $display("[TB] initial clear finished after %0d cycles", cnt);
    check("init_clear_len", 128'(cnt), 128'(SETS));

    // Every way of a few sets reads zero after the clear
    for (int w = 0; w < WAYS; w++) begin
      step(1'b1, 1'b0, 1'b0, 200 + w, w, 0, 4'h0, '0, 1'b0, acc);
      check("init_zero", rdata_o, 128'h0);
    end

    // Vector table, applied back-to-back with valid held high
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].we, vecs[i].fill, vecs[i].idx, vecs[i].way, vecs[i].word,
           vecs[i].be, vecs[i].wd, 1'b0, acc);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp);
    end

    // Write followed immediately by a read of the same line
    step(1'b1, 1'b1, 1'b0, 5, 2, 3, 4'b1000, 128'h99000000, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 5, 2, 0, 4'h0, '0, 1'b0, acc);
    check("raw_bypass", rdata_o, 128'h9923456789ABCDEF0123456789ABCDEF);

    // rdata holds through writes and idle cycles
    step(1'b1, 1'b1, 1'b1, 6, 1, 0, 4'h0, {4{32'h5A5A5A5A}}, 1'b0, acc);
    idle_step();
    check("rdata_hold", rdata_o, 128'h9923456789ABCDEF0123456789ABCDEF);

    // On-demand clear with a simultaneous read that must be refused
    step(1'b1, 1'b0, 1'b0, 6, 1, 0, 4'h0, '0, 1'b1, acc);
    check("clr_read_refused", {127'b0, rvalid_o}, 128'h0);
    busy_cycles = busy_o ? 1 : 0;
    wait_ready(cnt);
    busy_cycles += cnt - 1;
    $display("[TB] on-demand clear busy for %0d cycles", busy_cycles);
    check("clr_busy_len", 128'(busy_cycles), 128'(SETS));
    step(1'b1, 1'b0, 1'b0, 5, 2, 0, 4'h0, '0, 1'b0, acc);
    check("clr_zero_a", rdata_o, 128'h0);
    step(1'b1, 1'b0, 1'b0, 6, 1, 0, 4'h0, '0, 1'b0, acc);
    check("clr_zero_b", rdata_o, 128'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit v, we, fill, clr;
      v    = ($urandom_range(3) != 0);
      we   = $urandom_range(1);
      fill = ($urandom_range(3) == 0);
      clr  = ($urandom_range(199) == 0);
      step(v, we, fill, $urandom_range(15), $urandom_range(3), $urandom_range(3),
           4'($urandom_range(15)), {$urandom, $urandom, $urandom, $urandom}, clr, acc);
    end
    wait_ready(cnt);

    // Reset asserted one cycle after an accepted read
    step(1'b1, 1'b1, 1'b1, 3, 3, 0, 4'h0, {4{32'h13579BDF}}, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 3, 3, 0, 4'h0, '0, 1'b0, acc);
    idle_step();
    step(1'b1, 1'b0, 1'b0, 3, 3, 0, 4'h0, '0, 1'b0, acc);
    #1;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_rvalid", {127'b0, rvalid_o}, 128'h0);
    check("mid_rst_rdata", rdata_o, 128'h0);
    check("mid_rst_busy", {127'b0, busy_o}, 128'h1);
    model_rdata = '0;
    clear_left  = SETS;
    repeat (2) @(posedge clk_i);
    #1;
    check("mid_rst_no_result", {127'b0, rvalid_o}, 128'h0);
    rst_ni = 1'b1;
    wait_ready(cnt);
    $display("[TB] post-reset clear finished after %0d cycles", cnt);
    check("rerun_clear_len", 128'(cnt), 128'(SETS));
    step(1'b1, 1'b0, 1'b0, 3, 3, 0, 4'h0, '0, 1'b0, acc);
    check("rerun_zero", rdata_o, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
